mdio_slave_dri: RTL

//  - Clause-22 MDIO management target (PHY side). Oversamples the MDC/MDIO pins in the clk domain and decodes frames.
//  - Serves reads from, and forwards writes to, a 32x16 register bank over a simple strobe interface.
//  - Used as a loopback partner for the MDIO master driver in simulation and board self-test, and as a soft-PHY management port.

---
 rtl/mdio_slave_dri_pkg.sv | 31 +++
 rtl/mdio_slave_dri_edge_sync.sv | 35 +++
 rtl/mdio_slave_dri.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mdio_slave_dri_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdio_slave_dri_pkg : Clause-22 frame codes and target FSM states  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mdio_slave_dri_pkg;

  localparam logic [1:0] ST_CODE = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] TA_WR   = 2'b10;

  localparam logic [4:0] C_ADDR_LAST = 5'd4;
  localparam logic [4:0] C_DATA_LAST = 5'd15;
  localparam logic [4:0] C_RD_END    = 5'd16;
  localparam logic [4:0] C_SKIP_LAST = 5'd17;

  typedef enum logic [8:0] {
    S_IDLE  = 9'b000000001,
    S_ST    = 9'b000000010,
    S_OP    = 9'b000000100,
    S_PHYAD = 9'b000001000,
    S_REGAD = 9'b000010000,
    S_TA    = 9'b000100000,
    S_RDATA = 9'b001000000,
    S_WDATA = 9'b010000000,
    S_SKIP  = 9'b100000000
  } state_e;

endpackage : mdio_slave_dri_pkg
`default_nettype wire

// File: rtl/mdio_slave_dri_edge_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdio_slave_dri_edge_sync : 2-flop sync of MDC/MDIO, MDC rise pulse |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mdio_slave_dri_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_mdc,
  input  logic i_mdio,
  output logic o_mdc_rise,
  output logic o_mdio
);

  logic [1:0] r_mdc_sync;
  logic [1:0] r_mdio_sync;
  logic       r_mdc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mdc_sync  <= 2'b00;
      r_mdio_sync <= 2'b00;
      r_mdc_q     <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[0], i_mdc};
      r_mdio_sync <= {r_mdio_sync[0], i_mdio};
      r_mdc_q     <= r_mdc_sync[1];
    end
  end

  assign o_mdc_rise = r_mdc_sync[1] & ~r_mdc_q;
  assign o_mdio     = r_mdio_sync[1];

endmodule : mdio_slave_dri_edge_sync
`default_nettype wire

// File: rtl/mdio_slave_dri.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mdio_slave_dri : Clause-22 MDIO target serving a 32x16 reg bank    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mdio_slave_dri
  import mdio_slave_dri_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'b00001,
  parameter logic        BCAST_EN = 1'b0,
  parameter logic [5:0]  PRE_MIN  = 6'd32,
  parameter logic [15:0] TIMEOUT  = 16'd2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_rd_req,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        busy,
  output logic        frame_err
);

  state_e      r_state, w_state;
  logic [4:0]  r_cnt, w_cnt, w_addr, w_bits;
  logic [5:0]  r_pre, w_pre;
  logic [15:0] r_sh, w_sh, r_rdlat, w_wr_data, r_to;
  logic        r_rd, w_rd, r_match, w_match;
  logic        w_mdio_o, w_oe, w_rd_req, w_wr_pend, r_wr_pend, w_err, r_req_d;
  logic        w_rise, w_bit, w_timeout;

  mdio_slave_dri_edge_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mdc      (mdc),
    .i_mdio     (mdio_i),
    .o_mdc_rise (w_rise),
    .o_mdio     (w_bit)
  );

  assign w_timeout = (r_state != S_IDLE) && (r_to == TIMEOUT - 16'd1);

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_pre     = r_pre;
    w_sh      = r_sh;
    w_rd      = r_rd;
    w_match   = r_match;
    w_mdio_o  = mdio_o;
    w_oe      = mdio_oe;
    w_addr    = reg_addr;
    w_rd_req  = 1'b0;
    w_wr_data = reg_wr_data;
    w_wr_pend = 1'b0;
    w_err     = 1'b0;
    w_bits    = {r_sh[3:0], w_bit};
    if (w_rise) begin
      case (r_state)
        S_IDLE: begin
          if (w_bit) begin
            if (r_pre != 6'd63) w_pre = r_pre + 6'd1;
          end else if (r_pre >= PRE_MIN) begin
            w_state = S_ST;
          end else begin
            w_pre = '0;
          end
        end
        S_ST: begin
          w_cnt = '0;
          if (w_bit == ST_CODE[0]) w_state = S_OP;
          else begin w_err = 1'b1; w_state = S_IDLE; end
        end
        S_OP: begin
          w_sh  = {r_sh[14:0], w_bit};
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == 5'd1) begin
            w_cnt = '0;
            if ({r_sh[0], w_bit} == OP_RD)      begin w_rd = 1'b1; w_state = S_PHYAD; end
            else if ({r_sh[0], w_bit} == OP_WR) begin w_rd = 1'b0; w_state = S_PHYAD; end
            else begin w_err = 1'b1; w_state = S_IDLE; end
          end
        end
        S_PHYAD: begin
          w_sh  = {r_sh[14:0], w_bit};
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == C_ADDR_LAST) begin
            w_cnt   = '0;
            // broadcast address is only honoured for writes
            w_match = (w_bits == PHY_ADDR) || (BCAST_EN && (w_bits == 5'd0) && !r_rd);
            w_state = S_REGAD;
          end
        end
        S_REGAD: begin
          w_sh  = {r_sh[14:0], w_bit};
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == C_ADDR_LAST) begin
            w_cnt  = '0;
            w_addr = w_bits;
            if (r_match) begin w_state = S_TA; w_rd_req = r_rd; end
            else         w_state = S_SKIP;
          end
        end
        S_TA: begin
          w_cnt = r_cnt + 5'd1;
          if (r_rd) begin
            if (r_cnt == 5'd1) begin
              w_oe = 1'b1; w_mdio_o = 1'b0; w_sh = r_rdlat; w_cnt = '0; w_state = S_RDATA;
            end
          end else if (w_bit != ((r_cnt == 5'd0) ? TA_WR[1] : TA_WR[0])) begin
            w_err = 1'b1; w_state = S_SKIP;
          end else if (r_cnt == 5'd1) begin
            w_cnt = '0; w_state = S_WDATA;
          end
        end
        S_RDATA: begin
          if (r_cnt == C_RD_END) begin
            w_oe = 1'b0; w_mdio_o = 1'b1; w_state = S_IDLE;
          end else begin
            w_mdio_o = r_sh[15];
            w_sh     = {r_sh[14:0], 1'b0};
            w_cnt    = r_cnt + 5'd1;
          end
        end
        S_WDATA: begin
          w_sh  = {r_sh[14:0], w_bit};
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == C_DATA_LAST) begin
            w_wr_data = {r_sh[14:0], w_bit}; w_wr_pend = 1'b1; w_state = S_IDLE;
          end
        end
        S_SKIP: begin
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == C_SKIP_LAST) w_state = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_oe = 1'b0; w_mdio_o = 1'b1; w_err = 1'b1; w_state = S_IDLE;
    end
    if (w_state == S_IDLE && r_state != S_IDLE) w_pre = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pre       <= '0;
      r_sh        <= '0;
      r_rd        <= 1'b0;
      r_match     <= 1'b0;
      r_rdlat     <= '0;
      r_req_d     <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_to        <= '0;
      mdio_o      <= 1'b1;
      mdio_oe     <= 1'b0;
      reg_addr    <= '0;
      reg_rd_req  <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_pre       <= w_pre;
      r_sh        <= w_sh;
      r_rd        <= w_rd;
      r_match     <= w_match;
      r_req_d     <= reg_rd_req;
      if (r_req_d) r_rdlat <= reg_rd_data;
      r_wr_pend   <= w_wr_pend;
      r_to        <= (w_rise || r_state == S_IDLE) ? 16'd0 :
                     ((r_to == 16'hFFFF) ? r_to : r_to + 16'd1);
      mdio_o      <= w_mdio_o;
      mdio_oe     <= w_oe;
      reg_addr    <= w_addr;
      reg_rd_req  <= w_rd_req;
      reg_wr_en   <= r_wr_pend;
      reg_wr_data <= w_wr_data;
      busy        <= (w_state != S_IDLE);
      frame_err   <= w_err;
    end
  end

endmodule : mdio_slave_dri
`default_nettype wire
